// File: rtl/snake_pkg.sv
// Shared constants for the snake game: key indices, direction encoding, clock rate.
package snake_pkg;
  localparam int CLK_HZ    = 25_000_000;
  localparam int NUM_KEYS  = 4;
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Lowest set index wins, so up beats down beats left beats right.
  function automatic logic [NUM_KEYS-1:0] pick_first(input logic [NUM_KEYS-1:0] req);
    logic [NUM_KEYS-1:0] g;
    g = '0;
    for (int i = NUM_KEYS-1; i >= 0; i--)
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    return g;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, stability counter and debounced level,
// plus a combinational strobe on the edge where the level flips to pressed.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic clk_25MHz,
  input  logic reset,
  input  logic key_raw_n,
  output logic stable,
  output logic press
);
  logic             sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic             level, flip;

  assign level = ~sync2;
  assign flip  = (level != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES-1));
  assign press = flip && !stable;

  always_ff @(posedge clk_25MHz or posedge reset)
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_raw_n;
      sync2 <= sync1;
    end

  // Any sample that agrees with the accepted level restarts the run.
  always_ff @(posedge clk_25MHz or posedge reset)
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (level == stable) begin
      cnt <= '0;
    end else if (flip) begin
      stable <= ~stable;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/key_input_conditioner.sv
// Turns the four raw DE2-115 buttons into one-cycle direction strobes for
// game_control; simultaneous presses are queued and emitted in priority order.
module key_input_conditioner
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic                clk_25MHz,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                key_up,
  output logic                key_down,
  output logic                key_left,
  output logic                key_right,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_press
);
  logic [NUM_KEYS-1:0] stable, press, pending, grant, pulse;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk_25MHz(clk_25MHz),
      .reset    (reset),
      .key_raw_n(key_n[k]),
      .stable   (stable[k]),
      .press    (press[k])
    );
  end

  assign grant = pick_first(pending);

  // A fresh press on the edge its bit is granted keeps the bit pending.
  always_ff @(posedge clk_25MHz or posedge reset)
    if (reset) begin
      pending   <= '0;
      pulse     <= '0;
      any_press <= 1'b0;
    end else begin
      pending   <= (pending & ~grant) | press;
      pulse     <= grant;
      any_press <= |grant;
    end

  assign key_up    = pulse[KEY_UP];
  assign key_down  = pulse[KEY_DOWN];
  assign key_left  = pulse[KEY_LEFT];
  assign key_right = pulse[KEY_RIGHT];
  assign key_held  = stable;
endmodule
